input_debouncer: RTL
====================

Name: input_debouncer

Overview:
Upstream conditioning stage for the edge detector.
- Takes a raw asynchronous or bouncy pin (button, external strobe, handshake line).
- Synchronises it into the CLK domain, then qualifies each level change over a programmable number of consecutive cycles.
- Drives a clean, glitch-free level on SAMPLE_OUT, which feeds the edge detector's SAMPLE_IN directly.
- Also reports committed changes and rejected glitches as single-cycle pulses.

Parameters:
- SYNC_STAGES, 2, depth of the synchroniser flop chain; legal range is 2 or more.
- CNT_WIDTH, 16, width of the qualification counter and of DEBOUNCE_CYCLES.
- RESET_LEVEL, 1'b0, value loaded into the synchroniser chain and SAMPLE_OUT at reset.

Ports:
- CLK  input  1  system clock.
- RSTN  input  1  reset; synchronous, active-low.
- ASYNC_IN  input  1  raw input, asynchronous to CLK.
- ENABLE  input  1  qualification enable; when low, SAMPLE_OUT is frozen.
- DEBOUNCE_CYCLES  input  CNT_WIDTH  number of consecutive differing samples required to commit; sampled every cycle.
- SAMPLE_OUT  output  1  debounced level, fed to the edge detector.
- CHANGED_OUT  output  1  one-cycle pulse, coincident with the cycle SAMPLE_OUT takes its new value.
- GLITCH_OUT  output  1  one-cycle pulse when a pending change is abandoned.
- BUSY_OUT  output  1  high while in QUALIFY.

Behaviour:
- Reset (RSTN low at a CLK edge):
  - all synchroniser flops and SAMPLE_OUT load RESET_LEVEL;
  - FSM goes to STABLE; counter is cleared;
  - CHANGED_OUT, GLITCH_OUT and BUSY_OUT are 0.
  - Reset mid-QUALIFY abandons the change without a GLITCH_OUT pulse.
- Synchroniser:
  - ASYNC_IN shifts through SYNC_STAGES flops every cycle, regardless of ENABLE.
  - "synced" is the last stage.
- Effective threshold N:
  - N = DEBOUNCE_CYCLES, with 0 treated as 1.
- FSM, two states:
  - STABLE:
    - If ENABLE and synced differs from SAMPLE_OUT and N equals 1, commit.
    - Else if ENABLE and synced differs, go to QUALIFY with counter set to 1.
    - Otherwise stay.
  - QUALIFY:
    - If synced equals SAMPLE_OUT, go to STABLE, clear the counter and pulse GLITCH_OUT.
    - Else if counter+1 is N or more, commit.
    - Else increment the counter.
  - Commit: SAMPLE_OUT toggles to synced, CHANGED_OUT pulses, state goes to STABLE, counter is cleared.
- Latency:
  - If ASYNC_IN settles before edge 0, SAMPLE_OUT changes after edge SYNC_STAGES+N.
  - Example: SYNC_STAGES=2, N=4 gives 6 cycles.
  - The edge detector adds its own cycle downstream.
- ENABLE low:
  - forces STABLE and clears the counter;
  - no GLITCH_OUT pulse is emitted;
  - SAMPLE_OUT holds.
  - On re-enable, qualification restarts from 1.
- DEBOUNCE_CYCLES changed mid-QUALIFY:
  - the new value applies on the next edge;
  - if the counter is already at or above the new N-1, commit on that edge.
- Counter never wraps: commit occurs before it could exceed 2^CNT_WIDTH-1.
- Outputs:
  - All outputs are registered; there is no combinational path from ASYNC_IN to any output.
  - CHANGED_OUT and GLITCH_OUT are never high in the same cycle.

Decomposition:
- Shared package holds:
  - the FSM state localparams: STABLE=1'b0, QUALIFY=1'b1;
  - the default SYNC_STAGES constant, so every synchroniser in the design uses the same depth.
- Natural sub-module: bit_synchronizer, a parameterised flop chain with reset value.
  - Reusable elsewhere for CDC of single bits.
  - input_debouncer instantiates it once.

Test Plan:
- Reset with RESET_LEVEL=0 and ASYNC_IN=1 held throughout -> SAMPLE_OUT=0 and all pulses 0 during reset. After release with DEBOUNCE_CYCLES=4, SAMPLE_OUT=1 after edge 6 post-release, with CHANGED_OUT high for exactly that one cycle.
- DEBOUNCE_CYCLES=8, ASYNC_IN pulses high for 3 cycles then low -> GLITCH_OUT pulses once, SAMPLE_OUT stays 0, CHANGED_OUT never asserts, BUSY_OUT high for 3 cycles.
- DEBOUNCE_CYCLES=0 and 1, single clean 0->1 step -> SAMPLE_OUT rises after edge 3 in both cases.
- DEBOUNCE_CYCLES=10, ASYNC_IN high; drop ENABLE after 5 qualifying cycles, raise it 4 cycles later -> no GLITCH_OUT, SAMPLE_OUT still 0, commit 10 cycles after re-enable.
- DEBOUNCE_CYCLES=20 during QUALIFY with counter=6, then rewrite to 5 -> commit on the next edge with a single CHANGED_OUT pulse.
- Chain input_debouncer into the edge detector; drive a bouncy input (5 toggles of 2 cycles each, then a stable 1) with N=4 -> exactly one RISE_EDGE_OUT pulse and no FALL_EDGE_OUT.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer and its synchroniser.
// Holds the FSM state encoding and the design-wide synchroniser depth.
package input_debouncer_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Single-bit CDC flop chain with a parameterised reset value.
// The output is the last stage of the chain.
module bit_synchronizer
  import input_debouncer_pkg::*;
#(
  parameter int   STAGES    = DEFAULT_SYNC_STAGES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronises a raw pin and commits a level change only after N consecutive
// differing samples; reports commits and abandoned changes as pulses.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int   CNT_WIDTH   = 16,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 ASYNC_IN,
  input  logic                 ENABLE,
  input  logic [CNT_WIDTH-1:0] DEBOUNCE_CYCLES,
  output logic                 SAMPLE_OUT,
  output logic                 CHANGED_OUT,
  output logic                 GLITCH_OUT,
  output logic                 BUSY_OUT
);

  logic                 synced;
  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 sample, sample_next;
  logic                 changed, changed_next;
  logic                 glitch, glitch_next;
  logic [CNT_WIDTH-1:0] n_eff;
  logic [CNT_WIDTH:0]   cnt_inc;
  logic                 differs;

  bit_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .CLK  (CLK),
    .RSTN (RSTN),
    .d    (ASYNC_IN),
    .q    (synced)
  );

  // A threshold of 0 behaves like 1 so a change can never be held off forever.
  assign n_eff   = (DEBOUNCE_CYCLES == '0) ? CNT_WIDTH'(1) : DEBOUNCE_CYCLES;
  // One extra bit keeps the threshold compare exact at the top of the range.
  assign cnt_inc = (CNT_WIDTH+1)'(cnt) + (CNT_WIDTH+1)'(1);
  assign differs = (synced != sample);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    sample_next  = sample;
    changed_next = 1'b0;
    glitch_next  = 1'b0;

    if (!ENABLE) begin
      state_next = STABLE;
      cnt_next   = '0;
    end else begin
      case (state)
        STABLE: begin
          if (differs) begin
            if (n_eff == CNT_WIDTH'(1)) begin
              sample_next  = synced;
              changed_next = 1'b1;
              cnt_next     = '0;
            end else begin
              state_next = QUALIFY;
              cnt_next   = CNT_WIDTH'(1);
            end
          end
        end
        QUALIFY: begin
          if (!differs) begin
            state_next  = STABLE;
            cnt_next    = '0;
            glitch_next = 1'b1;
          end else if (cnt_inc >= {1'b0, n_eff}) begin
            state_next   = STABLE;
            sample_next  = synced;
            changed_next = 1'b1;
            cnt_next     = '0;
          end else begin
            cnt_next = cnt_inc[CNT_WIDTH-1:0];
          end
        end
      endcase
    end
  end

  // NOTE: reset is synchronous here, so it is only checked inside the clocked branch.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state   <= STABLE;
      cnt     <= '0;
      sample  <= RESET_LEVEL;
      changed <= 1'b0;
      glitch  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      sample  <= sample_next;
      changed <= changed_next;
      glitch  <= glitch_next;
    end
  end

  assign SAMPLE_OUT  = sample;
  assign CHANGED_OUT = changed;
  assign GLITCH_OUT  = glitch;
  assign BUSY_OUT    = (state == QUALIFY);

endmodule
